// File: rtl/fp_requant_pkg.sv
// Shared rounding-mode type and output range helpers for the stream requantiser.
`timescale 1ns/1ps
package fp_requant_pkg;

    typedef enum logic [1:0] {
        FP_TRUNC         = 2'd0,
        FP_ROUND_HALF_UP = 2'd1,
        FP_ROUND_CONV    = 2'd2
    } round_mode_e;

    function automatic longint fp_max(input int w, input bit sgn);
        if (sgn) return (longint'(1) << (w - 1)) - 1;
        return (longint'(1) << w) - 1;
    endfunction

    function automatic longint fp_min(input int w, input bit sgn);
        if (sgn) return -(longint'(1) << (w - 1));
        return 0;
    endfunction

endpackage

// File: rtl/fp_requant_lane.sv
// One channel of the requantiser: S1 rounds/shifts, S2 saturates; both stages advance on i_en.
`timescale 1ns/1ps
module fp_requant_lane
    import fp_requant_pkg::*;
#(
    parameter bit          IS_SIGNED = 1'b1,
    parameter int          IN_IW     = 4,
    parameter int          IN_QW     = 12,
    parameter int          OUT_IW    = 2,
    parameter int          OUT_QW    = 6,
    parameter round_mode_e ROUND     = FP_ROUND_HALF_UP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic [IN_IW+IN_QW-1:0]   i_dat,
    output logic [OUT_IW+OUT_QW-1:0] o_dat,
    output logic                     o_sat
);
    localparam int     IN_WL = IN_IW + IN_QW;
    localparam int     OW    = OUT_IW + OUT_QW;
    localparam int     D     = (IN_QW > OUT_QW) ? IN_QW - OUT_QW : 0;
    localparam int     L     = (OUT_QW > IN_QW) ? OUT_QW - IN_QW : 0;
    localparam int     SW    = IN_WL + 2 + L;
    localparam longint MAXV  = fp_max(OW, IS_SIGNED);
    localparam longint MINV  = fp_min(OW, IS_SIGNED);

    logic [IN_WL:0] w_ext;
    logic [IN_WL:0] w_shr;
    logic [SW-1:0]  w_s1;
    logic [SW-1:0]  r_s1;
    longint         w_v;
    logic           w_hi;
    logic           w_lo;
    logic [OW-1:0]  w_dat;
    logic [OW-1:0]  r_dat;
    logic           r_sat;

    // One guard bit: the top bit of w_ext/w_shr is the sign for sfp and always 0 for ufp.
    assign w_ext = IS_SIGNED ? {i_dat[IN_WL-1], i_dat} : {1'b0, i_dat};

    if (D > 0) begin : g_round
        localparam logic [IN_WL:0] HALF = (IN_WL + 1)'(1) << (D - 1);
        logic [IN_WL:0] w_bias;
        logic [IN_WL:0] w_sum;

        always_comb begin
            w_bias = '0;
            case (ROUND)
                FP_ROUND_HALF_UP: w_bias = HALF;
                FP_ROUND_CONV:    w_bias = HALF - 1'b1 + {{IN_WL{1'b0}}, w_ext[D]};
                default:          w_bias = '0;
            endcase
        end

        assign w_sum = w_ext + w_bias;

        always_comb begin
            if (IS_SIGNED) w_shr = $signed(w_sum) >>> D;
            else           w_shr = w_sum >> D;
        end
    end else begin : g_noround
        assign w_shr = w_ext;
    end

    assign w_s1 = {{(L + 1){w_shr[IN_WL]}}, w_shr} << L;

    assign w_v   = longint'($signed(r_s1));
    assign w_hi  = w_v > MAXV;
    assign w_lo  = w_v < MINV;
    assign w_dat = w_hi ? OW'(MAXV) : (w_lo ? OW'(MINV) : OW'(w_v));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1  <= '0;
            r_dat <= '0;
            r_sat <= 1'b0;
        end else if (i_en) begin
            r_s1  <= w_s1;
            r_dat <= w_dat;
            r_sat <= w_hi | w_lo;
        end
    end

    assign o_dat = r_dat;
    assign o_sat = r_sat;

endmodule

// File: rtl/fp_stream_requant.sv
// Multi-channel fixed-point requantiser, 2-cycle latency, stalls both stages while the output is held.
// Define FP_REQUANT_STATS_EN to add per-channel 16-bit saturation counters on sat_count.
`timescale 1ns/1ps
module fp_stream_requant
    import fp_requant_pkg::*;
#(
    parameter bit          IS_SIGNED = 1'b1,
    parameter int          IN_IW     = 4,
    parameter int          IN_QW     = 12,
    parameter int          OUT_IW    = 2,
    parameter int          OUT_QW    = 6,
    parameter int          NCH       = 2,
    parameter round_mode_e ROUND     = FP_ROUND_HALF_UP
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NCH*(IN_IW+IN_QW)-1:0]      in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NCH*(OUT_IW+OUT_QW)-1:0]    out_data,
    output logic [NCH-1:0]                    out_sat,
    output logic [NCH-1:0]                    sat_sticky,
`ifdef FP_REQUANT_STATS_EN
    output logic [NCH*16-1:0]                 sat_count,
`endif
    input  logic                              clr_sticky
);
    localparam int IN_WL = IN_IW + IN_QW;
    localparam int OW    = OUT_IW + OUT_QW;

    logic           w_en;
    logic           w_xfer;
    logic           r_s1_vld;
    logic           r_s2_vld;
    logic [NCH-1:0] r_sticky;

    assign w_en      = !r_s2_vld || out_ready;
    // The pipeline is empty while reset is held, so input is never refused then.
    assign in_ready  = w_en || !rst_n;
    assign out_valid = r_s2_vld;
    assign w_xfer    = r_s2_vld && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
        end else if (w_en) begin
            r_s1_vld <= in_valid;
            r_s2_vld <= r_s1_vld;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        fp_requant_lane #(
            .IS_SIGNED (IS_SIGNED),
            .IN_IW     (IN_IW),
            .IN_QW     (IN_QW),
            .OUT_IW    (OUT_IW),
            .OUT_QW    (OUT_QW),
            .ROUND     (ROUND)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (w_en),
            .i_dat (in_data[g*IN_WL +: IN_WL]),
            .o_dat (out_data[g*OW +: OW]),
            .o_sat (out_sat[g])
        );
    end

    // A saturating transfer in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) r_sticky <= '0;
        else        r_sticky <= (clr_sticky ? '0 : r_sticky) | (w_xfer ? out_sat : '0);
    end

    assign sat_sticky = r_sticky;

`ifdef FP_REQUANT_STATS_EN
    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        logic [15:0] r_cnt;

        always_ff @(posedge clk) begin
            if (!rst_n || clr_sticky)
                r_cnt <= '0;
            else if (w_xfer && out_sat[g] && (r_cnt != 16'hFFFF))
                r_cnt <= r_cnt + 16'd1;
        end

        assign sat_count[g*16 +: 16] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_fp_stream_requant.sv
// Directed bench for fp_stream_requant at default formats, with truncating and convergent instances alongside.
`timescale 1ns/1ps
module tb_fp_stream_requant;
    import fp_requant_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        clr_sticky;
    logic [31:0] in_data;

    logic        in_ready,  in_ready_tr,  in_ready_cv;
    logic        out_valid, out_valid_tr, out_valid_cv;
    logic [15:0] out_data,  od_tr,        od_cv;
    logic [1:0]  out_sat,   sat_tr,       sat_cv;
    logic [1:0]  sat_sticky, sticky_tr,   sticky_cv;
`ifdef FP_REQUANT_STATS_EN
    logic [31:0] cnt_hu, cnt_tr, cnt_cv;
`endif

    int checks   = 0;
    int failures = 0;
    int nxt_in;
    int nxt_out;
    logic [15:0] held;

    always #5 clk = ~clk;

    fp_stream_requant u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .sat_sticky(sat_sticky),
`ifdef FP_REQUANT_STATS_EN
        .sat_count(cnt_hu),
`endif
        .clr_sticky(clr_sticky)
    );

    fp_stream_requant #(.ROUND(FP_TRUNC)) u_dut_tr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_tr), .in_data(in_data),
        .out_valid(out_valid_tr), .out_ready(out_ready), .out_data(od_tr), .out_sat(sat_tr),
        .sat_sticky(sticky_tr),
`ifdef FP_REQUANT_STATS_EN
        .sat_count(cnt_tr),
`endif
        .clr_sticky(clr_sticky)
    );

    fp_stream_requant #(.ROUND(FP_ROUND_CONV)) u_dut_cv (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_cv), .in_data(in_data),
        .out_valid(out_valid_cv), .out_ready(out_ready), .out_data(od_cv), .out_sat(sat_cv),
        .sat_sticky(sticky_cv),
`ifdef FP_REQUANT_STATS_EN
        .sat_count(cnt_cv),
`endif
        .clr_sticky(clr_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane 0 carries k/64, lane 1 carries -k/64: both map exactly to +/-k LSBs of Q2.6.
    function automatic logic [31:0] vin(input int k);
        logic [15:0] a;
        logic [15:0] b;
        a = 16'(k * 64);
        b = 16'(-(k * 64));
        return {b, a};
    endfunction

    function automatic logic [15:0] vout(input int k);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'(k);
        b = 8'(-k);
        return {b, a};
    endfunction

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;
        in_data    = '0;
        #1;
        chk("rst_in_ready_early", 32'(in_ready), 32'd1);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_sat", 32'(out_sat), 32'h0);
        chk("rst_sticky", 32'(sat_sticky), 32'h0);
`ifdef FP_REQUANT_STATS_EN
        chk("rst_count", cnt_hu, 32'h0);
`endif

        // Exact value 1.5 -> 0x60 after two cycles.
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = {16'h0000, 16'h1800};
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        chk("exact_lat1_vld", 32'(out_valid), 32'd0);
        tick();
        chk("exact_vld", 32'(out_valid), 32'd1);
        chk("exact_data", 32'(out_data), 32'h0060);
        chk("exact_sat", 32'(out_sat), 32'h0);

        // +3.0 / -3.0 clamp to 0x7F / 0x80.
        in_valid = 1'b1;
        in_data  = {16'hD000, 16'h3000};
        tick();
        in_valid = 1'b0;
        tick();
        chk("sat_data", 32'(out_data), 32'h807F);
        chk("sat_flags", 32'(out_sat), 32'h3);
        chk("sat_sticky_pre", 32'(sat_sticky), 32'h0);
        tick();
        chk("sat_sticky_post", 32'(sat_sticky), 32'h3);
`ifdef FP_REQUANT_STATS_EN
        chk("sat_count", cnt_hu, 32'h0001_0001);
`endif

        // Rounding modes: {0x0060, 0x0020} then {0x0000, 0xFFE0}.
        in_valid = 1'b1;
        in_data  = {16'h0060, 16'h0020};
        tick();
        in_data  = {16'h0000, 16'hFFE0};
        tick();
        in_valid = 1'b0;
        chk("rnd_hu_a", 32'(out_data), 32'h0201);
        chk("rnd_tr_a", 32'(od_tr), 32'h0100);
        chk("rnd_cv_a", 32'(od_cv), 32'h0200);
        chk("rnd_tr_vld", 32'(out_valid_tr), 32'd1);
        tick();
        chk("rnd_hu_b", 32'(out_data), 32'h0000);
        chk("rnd_tr_b", 32'(od_tr), 32'h00FF);
        chk("rnd_cv_b", 32'(od_cv), 32'h0000);
        chk("rnd_cv_sat", 32'(sat_cv), 32'h0);

        // Clear coincident with a lane-0 saturating transfer: lane 0 stays set.
        in_valid = 1'b1;
        in_data  = {16'h0000, 16'h3000};
        tick();
        in_valid = 1'b0;
        tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("clr_vs_set", 32'(sat_sticky), 32'h1);
`ifdef FP_REQUANT_STATS_EN
        chk("clr_count", cnt_hu, 32'h0);
`endif

        // Backpressure: continuous input, out_ready low for the first five cycles.
        nxt_in  = 1;
        nxt_out = 1;
        held    = '0;
        for (int c = 0; c < 24; c++) begin
            out_ready = (c >= 5);
            in_valid  = (nxt_in <= 8);
            in_data   = vin(nxt_in);
            @(negedge clk);
            if (c == 4) chk("bp_in_ready", 32'(in_ready), 32'd0);
            if (c == 2) held = out_data;
            if (c == 3 || c == 4) chk("bp_hold", 32'(out_data), 32'(held));
            if (out_valid && out_ready) begin
                chk("bp_order", 32'(out_data), 32'(vout(nxt_out)));
                nxt_out++;
            end
            if (in_valid && in_ready) nxt_in++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(nxt_in), 32'd9);
        chk("bp_delivered", 32'(nxt_out), 32'd9);

        // Reset with both stages full drops the in-flight vectors.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = vin(3);
        tick();
        in_data   = vin(4);
        tick();
        in_valid  = 1'b0;
        chk("rst_mid_pre_vld", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("rst_mid_vld", 32'(out_valid), 32'd0);
        chk("rst_mid_data", 32'(out_data), 32'h0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rst_mid_stale", 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_stream_requant.md
FP_STREAM_REQUANT -- requirements
Module: fp_stream_requant

Interface
REQ-001 Parameter IS_SIGNED, default 1: 1 = two's-complement data (sfp), 0 = unsigned (ufp).
REQ-002 Parameter IN_IW, default 4: input integer bits, sign included.
REQ-003 Parameter IN_QW, default 12: input fractional bits.
REQ-004 Parameter OUT_IW, default 2: output integer bits, sign included.
REQ-005 Parameter OUT_QW, default 6: output fractional bits.
REQ-006 Parameter NCH, default 2: channel count, 1..64.
REQ-007 Parameter ROUND, default FP_ROUND_HALF_UP: one of FP_TRUNC, FP_ROUND_HALF_UP, FP_ROUND_CONV.
REQ-008 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-009 Port rst_n, input, 1: synchronous reset, active-low.
REQ-010 Port in_valid, input, 1: in_data holds a valid sample vector.
REQ-011 Port in_ready, output, 1: block accepts in_data this cycle.
REQ-012 Port in_data, input, NCH x (IN_IW+IN_QW), packed: per-channel input samples, channel 0 in the LSBs.
REQ-013 Port out_valid, output, 1: out_data and out_sat are valid.
REQ-014 Port out_ready, input, 1: downstream accepts out_data this cycle.
REQ-015 Port out_data, output, NCH x (OUT_IW+OUT_QW), packed: requantised samples.
REQ-016 Port out_sat, output, NCH: per-channel flag, set when the current out_data lane was clipped.
REQ-017 Port sat_sticky, output, NCH: per-channel sticky saturation flags.
REQ-018 Port clr_sticky, input, 1: one-cycle pulse that clears sat_sticky and the statistics.

Function
REQ-019 Datapath: two-stage pipeline; S1 performs round/shift, S2 performs saturation; latency 2 cycles from input transfer to out_valid; throughput 1 vector per cycle.
REQ-020 Stall control: enable = !s2_valid || out_ready; in_ready = enable (combinational path from out_ready permitted); both stages advance only when enable is high.
REQ-021 Bubbles: bubbles are not collapsed; an invalid S1 moves into S2 as invalid.
REQ-022 Output hold: while out_valid && !out_ready, out_data and out_sat are held stable.
REQ-023 Shift: if IN_QW > OUT_QW, drop D = IN_QW-OUT_QW LSBs under ROUND; if IN_QW <= OUT_QW, shift left by OUT_QW-IN_QW with zero fill and no rounding.
REQ-024 FP_TRUNC: floor, i.e. arithmetic shift right.
REQ-025 FP_ROUND_HALF_UP: add 2^(D-1), then floor.
REQ-026 FP_ROUND_CONV: round to nearest, ties to even.
REQ-027 Rounding width: rounding is computed in IN_WL+1 bits, so the bias add never wraps.
REQ-028 Saturation: a result outside the output range clamps to the range limit (signed: -2^(OW-1)..2^(OW-1)-1; unsigned: 0..2^OW-1, where OW = OUT_IW+OUT_QW), and out_sat for that lane is 1.
REQ-029 Sticky flags: sat_sticky[i] sets on an output transfer (out_valid && out_ready) with out_sat[i] = 1, and clears on clr_sticky; when both occur in the same cycle, set wins.
REQ-030 Channels: channels are independent; identical ROUND mode and formats apply to all lanes.

Reset
REQ-031 On rst_n = 0 at a clock edge: s1_valid = 0, s2_valid = 0, out_valid = 0, out_data = 0, out_sat = 0, sat_sticky = 0, statistics counters = 0.
REQ-032 Mid-transfer reset: reset mid-stream discards in-flight vectors without emitting them.
REQ-033 in_ready during reset: in_ready is 1 during and after reset (the pipeline is empty).

Configuration
REQ-034 Macro FP_REQUANT_STATS_EN defined: adds output sat_count, NCH x 16 bits, per-channel saturation-event counters.
REQ-035 Counter behaviour: each counter increments on each transfer with out_sat[i] = 1, saturates at 0xFFFF, and clears on clr_sticky (clear wins over increment).
REQ-036 Macro FP_REQUANT_STATS_EN undefined: the sat_count port and counters are absent, and all other behaviour is identical.

Structure
REQ-037 Shared package fp_requant_pkg: holds enum round_mode_e (FP_TRUNC, FP_ROUND_HALF_UP, FP_ROUND_CONV) and constant functions for output min/max limits given width and signedness.
REQ-038 Sub-module fp_requant_lane: contains one channel's S1/S2 datapath registers, generated NCH times; handshake and sticky/stat logic reside in the top level.

Verification (defaults: signed, Q4.12 -> Q2.6, NCH = 2)
REQ-039 Exact value: in_data lane 0 = 0x1800 (1.5) -> out_data 0x60 two cycles later, out_sat = 0.
REQ-040 Saturation: lane 0 = 0x3000 (+3.0), lane 1 = 0xD000 (-3.0) -> out 0x7F / 0x80, out_sat = 2'b11, sat_sticky = 2'b11 after the transfer.
REQ-041 Rounding: inputs 0x0020, 0x0060, 0xFFE0 give the following outputs.
- FP_TRUNC: 0x00 / 0x01 / 0xFF.
- FP_ROUND_HALF_UP: 0x01 / 0x02 / 0x00.
- FP_ROUND_CONV: 0x00 / 0x02 / 0x00.
REQ-042 Backpressure: continuous in_valid with out_ready = 0 for 5 cycles -> in_ready = 0 after two vectors are held, out_data stays stable, and no vector is lost or duplicated after release.
REQ-043 Clear vs set: clr_sticky in the same cycle as a saturating transfer -> sat_sticky = 1; with FP_REQUANT_STATS_EN, sat_count = 0.
REQ-044 Reset mid-stream: rst_n = 0 with both stages valid -> out_valid = 0 next cycle, and no stale vector appears afterwards.
